cart_rom_arbiter: RTL and testbench
===================================

Name: cart_rom_arbiter

Overview:
- Shares the single cartridge ROM read port (rom_addr/rom_ce_n/rom_oe_n/rom_word/rom_q) between two requesters.
- Port A is the SNES bus side mapper path. Port B is the coprocessor fetch path (GSU/SA1/CX4/SPC7110 engines).
- Sits between the active mapper's coprocessor logic and the top-level ROM mux.
- Fixed priority to A, with a starvation guard for B and a fixed-latency read sequencer.

Parameters:
ROM_LAT, 2, cycles rom_q takes to become valid after rom_oe_n falls (range 1..15)
A_STREAK_MAX, 4, consecutive A grants allowed while B is pending before B is forced (range 1..15)

Ports:
mclk  input  1  master clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
pause  input  1  inhibits new grants (refresh/DMA window); an access already in flight completes
a_req  input  1  port A request, level
a_addr  input  24  port A byte address
a_word  input  1  port A: 1 = 16-bit read, 0 = byte read
a_ack  output  1  port A one-cycle completion pulse
b_req  input  1  port B request, level
b_addr  input  24  port B byte address
b_word  input  1  port B: 1 = 16-bit read, 0 = byte read
b_ack  output  1  port B one-cycle completion pulse
rdata  output  16  read data; valid only in the cycle a_ack or b_ack is high
rom_addr  output  24  ROM address
rom_ce_n  output  1  ROM chip enable, active-low
rom_oe_n  output  1  ROM output enable, active-low
rom_word  output  1  ROM word-access flag
rom_q  input  16  ROM data
busy  output  1  high whenever state is not IDLE
owner_b  output  1  1 = current or most recent grant went to B

Behaviour:
- Reset values: rom_ce_n=1, rom_oe_n=1, rom_word=0, rom_addr=0, a_ack=0, b_ack=0, rdata=0, busy=0, owner_b=0, streak=0, state=IDLE.
- Reset is honoured in any state. An in-flight access is abandoned with no ack, and the outputs take their reset values on the next edge.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE, grant decision (only when pause=0 and at least one request is high):
  - Only a_req high: grant A.
  - Only b_req high: grant B.
  - Both high: grant B if streak == A_STREAK_MAX, otherwise grant A.
- On grant:
  - Register the winner's addr/word into rom_addr/rom_word.
  - Set owner_b.
  - Drive rom_ce_n=0 and rom_oe_n=0 from the next cycle.
  - Load cnt=ROM_LAT and enter ACCESS.
- streak (4 bits):
  - A granted while b_req is high: increment, saturating at A_STREAK_MAX.
  - B granted: clear.
  - A granted with b_req low: clear.
- ACCESS:
  - rom_ce_n and rom_oe_n are low; rom_addr and rom_word are held stable.
  - cnt decrements each cycle.
  - In the cycle cnt==1: capture rom_q, go to DONE.
- Capture rule:
  - word=1: rdata = rom_q.
  - word=0: rdata = {8'h00, addr[0] ? rom_q[15:8] : rom_q[7:0]}.
- DONE:
  - rom_ce_n=1 and rom_oe_n=1.
  - Pulse the owner's ack for exactly one cycle; rdata is valid that cycle.
  - Return to IDLE.
- Latency: req seen in IDLE at cycle 0 -> ack at cycle ROM_LAT+2. Minimum spacing between back-to-back grants is ROM_LAT+2 cycles, because IDLE always lasts at least one cycle.
- Handshake:
  - Requester holds req, addr and word stable until its ack.
  - If req is still high in the IDLE cycle after ack, it is treated as a new request.
  - Dropping req before ack does not cancel the access: the ack still fires and is ignored by the requester.
- Simultaneous events:
  - pause rising during ACCESS has no effect on the current access.
  - pause high in IDLE blocks grants; streak is unchanged.
- a_ack and b_ack are never high together. rdata holds its last value outside ack cycles.
- Address and control are registered outputs; there is no combinational path from req to the rom_* outputs.

Test Plan:
- Reset, then a_req=1, a_addr=24'h008001, a_word=0, ROM model returns 16'hBEEF, ROM_LAT=2 -> rom_oe_n low cycles 1-2, a_ack at cycle 4, rdata=16'h00BE, owner_b=0.
- b_req only, b_addr=24'h100000, b_word=1, rom_q=16'h1234 -> b_ack at cycle 4, rdata=16'h1234, a_ack never high.
- a_req and b_req both held high, A_STREAK_MAX=4 -> grant order A,A,A,A,B,A,A,A,A,B; never more than 4 consecutive A grants while B waits.
- pause=1 with both reqs high for 10 cycles -> rom_ce_n stays 1, busy=0, no ack; pause released -> A granted next cycle.
- pause asserted in the first ACCESS cycle -> access completes, ack at the normal cycle, no further grant while pause=1.
- rst asserted during ACCESS -> next cycle rom_ce_n=1, rom_oe_n=1, busy=0, no ack issued; after rst deasserts, a held a_req is re-served with full latency.

Source files
------------

// File: rtl/cart_rom_arbiter.sv
// rtl/cart_rom_arbiter.sv - two-port cartridge ROM read arbiter with fixed A priority and B starvation guard
module cart_rom_arbiter #(
  parameter int ROM_LAT      = 2,
  parameter int A_STREAK_MAX = 4
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        pause,
  input  logic        a_req,
  input  logic [23:0] a_addr,
  input  logic        a_word,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [23:0] b_addr,
  input  logic        b_word,
  output logic        b_ack,
  output logic [15:0] rdata,
  output logic [23:0] rom_addr,
  output logic        rom_ce_n,
  output logic        rom_oe_n,
  output logic        rom_word,
  input  logic [15:0] rom_q,
  output logic        busy,
  output logic        owner_b
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(ROM_LAT);
  localparam logic [3:0] STREAK_CAP = 4'(A_STREAK_MAX);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  streak_q;
  logic [23:0] rom_addr_q;
  logic        rom_word_q;
  logic        rom_ce_n_q;
  logic        rom_oe_n_q;
  logic        a_ack_q;
  logic        b_ack_q;
  logic [15:0] rdata_q;
  logic [15:0] data_q;
  logic        busy_q;
  logic        owner_b_q;

  logic        grant_a_d;
  logic        grant_b_d;
  logic [15:0] cap_d;
  logic [3:0]  streak_d;

  always_comb begin
    grant_b_d = !pause && b_req && (!a_req || (streak_q == STREAK_CAP));
    grant_a_d = !pause && a_req && !grant_b_d;

    if (rom_word_q) begin
      cap_d = rom_q;
    end else begin
      cap_d = {8'h00, rom_addr_q[0] ? rom_q[15:8] : rom_q[7:0]};
    end

    // Streak only counts A wins that made B wait.
    streak_d = 4'd0;
    if (grant_a_d && b_req) begin
      streak_d = (streak_q == STREAK_CAP) ? streak_q : streak_q + 4'd1;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      streak_q   <= 4'd0;
      rom_addr_q <= 24'd0;
      rom_word_q <= 1'b0;
      rom_ce_n_q <= 1'b1;
      rom_oe_n_q <= 1'b1;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      rdata_q    <= 16'd0;
      data_q     <= 16'd0;
      busy_q     <= 1'b0;
      owner_b_q  <= 1'b0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_a_d || grant_b_d) begin
            rom_addr_q <= grant_b_d ? b_addr : a_addr;
            rom_word_q <= grant_b_d ? b_word : a_word;
            owner_b_q  <= grant_b_d;
            rom_ce_n_q <= 1'b0;
            rom_oe_n_q <= 1'b0;
            cnt_q      <= LAT_INIT;
            streak_q   <= streak_d;
            busy_q     <= 1'b1;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            data_q     <= cap_d;
            rom_ce_n_q <= 1'b1;
            rom_oe_n_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          // rdata is published together with the ack so it only changes in ack cycles.
          a_ack_q <= !owner_b_q;
          b_ack_q <= owner_b_q;
          rdata_q <= data_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign rdata    = rdata_q;
  assign rom_addr = rom_addr_q;
  assign rom_ce_n = rom_ce_n_q;
  assign rom_oe_n = rom_oe_n_q;
  assign rom_word = rom_word_q;
  assign busy     = busy_q;
  assign owner_b  = owner_b_q;

endmodule

// File: tb/tb_cart_rom_arbiter.sv
// tb/tb_cart_rom_arbiter.sv - directed table-driven bench for cart_rom_arbiter
module tb_cart_rom_arbiter;

  localparam int ROM_LAT      = 2;
  localparam int A_STREAK_MAX = 4;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic        a_req = 1'b0;
  logic [23:0] a_addr = 24'd0;
  logic        a_word = 1'b0;
  logic        a_ack;
  logic        b_req = 1'b0;
  logic [23:0] b_addr = 24'd0;
  logic        b_word = 1'b0;
  logic        b_ack;
  logic [15:0] rdata;
  logic [23:0] rom_addr;
  logic        rom_ce_n;
  logic        rom_oe_n;
  logic        rom_word;
  logic [15:0] rom_q;
  logic        busy;
  logic        owner_b;

  logic [15:0] rom_data = 16'h0000;
  int          lowcnt = 0;

  int errors = 0;
  int checks = 0;

  cart_rom_arbiter #(.ROM_LAT(ROM_LAT), .A_STREAK_MAX(A_STREAK_MAX)) dut (
    .mclk(mclk), .rst(rst), .pause(pause),
    .a_req(a_req), .a_addr(a_addr), .a_word(a_word), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_word(b_word), .b_ack(b_ack),
    .rdata(rdata), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
    .rom_word(rom_word), .rom_q(rom_q), .busy(busy), .owner_b(owner_b)
  );

  always #5 mclk = ~mclk;

  // ROM data is only valid once OE has been low for ROM_LAT cycles.
  always @(posedge mclk) lowcnt <= rom_oe_n ? 0 : lowcnt + 1;
  assign rom_q = (!rom_oe_n && lowcnt >= ROM_LAT - 1) ? rom_data : 16'hDEAD;

  typedef struct {
    logic        a_req;
    logic [23:0] a_addr;
    logic        a_word;
    logic        b_req;
    logic [23:0] b_addr;
    logic        b_word;
    logic [15:0] data;
    logic        exp_b;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_ack(output int n, output logic got_a, output logic got_b);
    n = 0;
    got_a = 1'b0;
    got_b = 1'b0;
    while (!(got_a || got_b) && n < 20) begin
      step();
      n++;
      if (n == 1) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
      got_a = a_ack;
      got_b = b_ack;
    end
    if (!(got_a || got_b)) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          n;
    logic        ga;
    logic        gb;
    logic        done;
    logic        bad;
    logic [23:0] exp_addr;
    logic        exp_word;
    logic [15:0] prev_rdata;
    logic [9:0]  order;
    int          acks;
    int          last_ack;

    vecs[0] = '{1'b1, 24'h008001, 1'b0, 1'b0, 24'h000000, 1'b0, 16'hBEEF, 1'b0, 16'h00BE};
    vecs[1] = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h100000, 1'b1, 16'h1234, 1'b1, 16'h1234};
    vecs[2] = '{1'b1, 24'h008000, 1'b0, 1'b0, 24'h000000, 1'b0, 16'hBEEF, 1'b0, 16'h00EF};
    vecs[3] = '{1'b1, 24'h00FFFE, 1'b1, 1'b0, 24'h000000, 1'b0, 16'hCAFE, 1'b0, 16'hCAFE};
    vecs[4] = '{1'b0, 24'h000000, 1'b0, 1'b1, 24'h123457, 1'b0, 16'h5AA5, 1'b1, 16'h005A};
    vecs[5] = '{1'b1, 24'h000010, 1'b1, 1'b1, 24'h200000, 1'b0, 16'h7788, 1'b0, 16'h7788};

    step();
    step();
    chk("reset_ce_n", 32'(rom_ce_n), 32'd1);
    chk("reset_oe_n", 32'(rom_oe_n), 32'd1);
    chk("reset_word", 32'(rom_word), 32'd0);
    chk("reset_addr", 32'(rom_addr), 32'd0);
    chk("reset_acks", {30'd0, a_ack, b_ack}, 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_owner_b", 32'(owner_b), 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      a_req = vecs[i].a_req; a_addr = vecs[i].a_addr; a_word = vecs[i].a_word;
      b_req = vecs[i].b_req; b_addr = vecs[i].b_addr; b_word = vecs[i].b_word;
      rom_data = vecs[i].data;
      exp_addr = vecs[i].exp_b ? vecs[i].b_addr : vecs[i].a_addr;
      exp_word = vecs[i].exp_b ? vecs[i].b_word : vecs[i].a_word;
      prev_rdata = rdata;
      n = 0;
      done = 1'b0;
      while (!done && n < 20) begin
        step();
        n++;
        if (n == 1) begin
          a_req = 1'b0;
          b_req = 1'b0;
          chk("v_rom_addr", 32'(rom_addr), 32'(exp_addr));
          chk("v_rom_word", 32'(rom_word), 32'(exp_word));
          chk("v_owner_b", 32'(owner_b), 32'(vecs[i].exp_b));
          chk("v_oe_c1", {30'd0, rom_oe_n, rom_ce_n}, 32'd0);
        end
        if (n == 2) chk("v_oe_c2", {30'd0, rom_oe_n, rom_ce_n}, 32'd0);
        if (n == 3) begin
          chk("v_oe_c3", {30'd0, rom_oe_n, rom_ce_n}, 32'd3);
          chk("v_busy_c3", 32'(busy), 32'd1);
          chk("v_rdata_hold", 32'(rdata), 32'(prev_rdata));
        end
        if (a_ack || b_ack) begin
          done = 1'b1;
          chk("v_latency", 32'(n), 32'(ROM_LAT + 2));
          chk("v_b_ack", 32'(b_ack), 32'(vecs[i].exp_b));
          chk("v_a_ack", 32'(a_ack), 32'(!vecs[i].exp_b));
          chk("v_rdata", 32'(rdata), 32'(vecs[i].exp_rdata));
          chk("v_busy_ack", 32'(busy), 32'd0);
        end
      end
      if (!done) chk("v_ack_timeout", 32'd0, 32'd1);
    end

    // Starvation guard: both requests held.
    rst = 1'b1; step(); rst = 1'b0;
    a_req = 1'b1; a_addr = 24'h000100; a_word = 1'b1;
    b_req = 1'b1; b_addr = 24'h300000; b_word = 1'b1;
    rom_data = 16'h4242;
    order = 10'd0;
    acks = 0;
    last_ack = 0;
    bad = 1'b0;
    for (int c = 1; c <= 200 && acks < 10; c++) begin
      step();
      if (a_ack && b_ack) bad = 1'b1;
      if (a_ack || b_ack) begin
        order[acks] = b_ack;
        if (acks > 0) chk("streak_gap", 32'(c - last_ack), 32'(ROM_LAT + 2));
        last_ack = c;
        acks++;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    chk("streak_ack_count", 32'(acks), 32'd10);
    chk("streak_order", 32'(order), 32'b1000010000);
    chk("streak_dual_ack", 32'(bad), 32'd0);
    step(); step(); step(); step();

    // Pause blocks grants in IDLE.
    rst = 1'b1; step(); rst = 1'b0;
    pause = 1'b1;
    a_req = 1'b1; b_req = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (!rom_ce_n || busy || a_ack || b_ack) bad = 1'b1;
    end
    chk("pause_blocks", 32'(bad), 32'd0);
    pause = 1'b0;
    step();
    chk("pause_release_busy", 32'(busy), 32'd1);
    chk("pause_release_owner", 32'(owner_b), 32'd0);
    a_req = 1'b0; b_req = 1'b0;
    n = 1;
    ga = 1'b0; gb = 1'b0;
    while (!(ga || gb) && n < 20) begin
      step();
      n++;
      ga = a_ack;
      gb = b_ack;
    end
    chk("pause_release_ack", {30'd0, ga, gb}, 32'd2);
    chk("pause_release_lat", 32'(n), 32'(ROM_LAT + 2));

    // Pause rising in the first ACCESS cycle.
    step();
    a_req = 1'b1; a_addr = 24'h000201; a_word = 1'b0;
    rom_data = 16'hA55A;
    n = 0;
    ga = 1'b0; gb = 1'b0;
    while (!(ga || gb) && n < 20) begin
      step();
      n++;
      if (n == 1) pause = 1'b1;
      ga = a_ack;
      gb = b_ack;
    end
    chk("pause_access_lat", 32'(n), 32'(ROM_LAT + 2));
    chk("pause_access_ack", {30'd0, ga, gb}, 32'd2);
    chk("pause_access_rdata", 32'(rdata), 32'h00A5);
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (busy || !rom_ce_n || a_ack || b_ack) bad = 1'b1;
    end
    chk("pause_no_regrant", 32'(bad), 32'd0);
    a_req = 1'b0;
    pause = 1'b0;
    step();

    // Reset during ACCESS abandons the access.
    a_req = 1'b1; a_addr = 24'h000400; a_word = 1'b1;
    rom_data = 16'h0F0F;
    step();
    chk("rst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_ce_oe", {30'd0, rom_oe_n, rom_ce_n}, 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
    rst = 1'b0;
    wait_ack(n, ga, gb);
    chk("rst_reserve_lat", 32'(n), 32'(ROM_LAT + 2));
    chk("rst_reserve_ack", {30'd0, ga, gb}, 32'd2);
    chk("rst_reserve_rdata", 32'(rdata), 32'h0F0F);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
